// File: rtl/ssd_scan_ctrl_if.sv
// Load handshake bundle for ssd_scan_ctrl: hex value bank, load strobe and
// pending flag. Optional per-digit decimal points exist only when SSD_DP_EN
// is defined.
interface ssd_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic                    pending;
`ifdef SSD_DP_EN
    logic [NUM_DIGITS-1:0]   dp;

    modport master (output value, output load, output dp, input pending);
    modport slave  (input value, input load, input dp, output pending);
`else
    modport master (output value, output load, input pending);
    modport slave  (input value, input load, output pending);
`endif
endinterface

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed common-anode seven-segment scanner with a
// double-buffered hex bank, per-digit enable, leading-zero blanking, PWM
// brightness and a frame-synchronous load handshake. All pins active-low.
// Optional feature macro: SSD_DP_EN (adds staged per-digit decimal points).
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_COUNT  = 1250,
    parameter int BRIGHT_W   = 3
) (
    input  logic                  x1,
    input  logic                  reset,
    ssd_scan_ctrl_if.slave        bus,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic                  lz_blank,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic                  frame_start,
    output logic [NUM_DIGITS-1:0] anodes,
    output logic [7:0]            SSD
);

    localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_W-1:0]        r_div;
    logic [IDX_W-1:0]        r_idx;
    logic [BRIGHT_W-1:0]     r_pwm;
    logic [4*NUM_DIGITS-1:0] r_stage;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic                    r_pending;
    logic                    r_frame_start;
    logic [NUM_DIGITS-1:0]   r_anodes;
    logic [7:0]              r_ssd;

    logic                    w_tick;
    logic                    w_frame_tick;
    logic [IDX_W-1:0]        w_idx_next;
    logic [BRIGHT_W-1:0]     w_pwm_next;
    logic                    w_pwm_on;
    logic [4*NUM_DIGITS-1:0] w_disp_next;
    logic [NUM_DIGITS-1:0]   w_lit;
    logic [3:0]              w_sel_nib;
    logic [7:0]              w_seg;
    logic                    w_dp_bit;
    logic [NUM_DIGITS-1:0]   w_onehot;

    function automatic logic [7:0] f_decode(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0: code = 8'hC0;
            4'h1: code = 8'hF9;
            4'h2: code = 8'hA4;
            4'h3: code = 8'hB0;
            4'h4: code = 8'h99;
            4'h5: code = 8'h92;
            4'h6: code = 8'h82;
            4'h7: code = 8'hF8;
            4'h8: code = 8'h80;
            4'h9: code = 8'h90;
            4'hA: code = 8'h88;
            4'hB: code = 8'h83;
            4'hC: code = 8'hC6;
            4'hD: code = 8'hA1;
            4'hE: code = 8'h86;
            default: code = 8'h8E;
        endcase
        return code;
    endfunction

    // Outputs are registered from next-state values so anodes/SSD move on
    // the same edge as the digit index, one cycle after the tick.
    assign w_tick       = (r_div == DIV_W'(DIV_COUNT - 1));
    assign w_frame_tick = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_idx_next   = !w_tick ? r_idx :
                          (w_frame_tick ? '0 : r_idx + IDX_W'(1));
    assign w_pwm_next   = r_pwm + BRIGHT_W'(1);
    assign w_pwm_on     = (&brightness) || (w_pwm_next < brightness);
    // A load coincident with the frame boundary bypasses staging.
    assign w_disp_next  = !w_frame_tick ? r_disp :
                          (bus.load ? bus.value : r_stage);
    assign w_sel_nib    = w_disp_next[4*w_idx_next +: 4];
    assign w_seg        = f_decode(w_sel_nib);
    assign w_onehot     = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_idx_next;

`ifdef SSD_DP_EN
    logic [NUM_DIGITS-1:0] r_dp_stage;
    logic [NUM_DIGITS-1:0] r_dp_disp;
    logic [NUM_DIGITS-1:0] w_dp_disp_next;

    assign w_dp_disp_next = !w_frame_tick ? r_dp_disp :
                            (bus.load ? bus.dp : r_dp_stage);
    assign w_dp_bit       = ~w_dp_disp_next[w_idx_next];

    // Decimal-point staging and display banks follow the value handshake.
    always_ff @(posedge x1) begin
        if (reset) begin
            r_dp_stage <= '0;
            r_dp_disp  <= '0;
        end else begin
            if (bus.load) r_dp_stage <= bus.dp;
            r_dp_disp <= w_dp_disp_next;
        end
    end
`else
    assign w_dp_bit = 1'b1;
`endif

    // Lit mask: enable plus leading-zero suppression scanned from the top digit.
    always_comb begin
        logic       v_higher_dark;
        logic [3:0] v_nib;
        int unsigned k;
        v_higher_dark = 1'b1;
        v_nib         = '0;
        k             = 0;
        w_lit         = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            k        = NUM_DIGITS - 1 - j;
            v_nib    = w_disp_next[4*k +: 4];
            w_lit[k] = digit_en[k] &&
                       !(lz_blank && (k != 0) && (v_nib == 4'h0) && v_higher_dark);
            v_higher_dark = v_higher_dark && ((v_nib == 4'h0) || !digit_en[k]);
        end
    end

    // Divider, scan index, PWM counter, banks, handshake and pin registers.
    always_ff @(posedge x1) begin
        if (reset) begin
            r_div         <= '0;
            r_idx         <= '0;
            r_pwm         <= '0;
            r_stage       <= '0;
            r_disp        <= '0;
            r_pending     <= 1'b0;
            r_frame_start <= 1'b0;
            r_anodes      <= '1;
            r_ssd         <= 8'hFF;
        end else begin
            r_div         <= w_tick ? '0 : r_div + DIV_W'(1);
            r_idx         <= w_idx_next;
            r_pwm         <= w_pwm_next;
            r_disp        <= w_disp_next;
            r_frame_start <= w_frame_tick;
            if (bus.load) r_stage <= bus.value;
            if (w_frame_tick)  r_pending <= 1'b0;
            else if (bus.load) r_pending <= 1'b1;
            if (w_lit[w_idx_next]) begin
                r_ssd    <= {w_dp_bit, w_seg[6:0]};
                r_anodes <= w_pwm_on ? ~w_onehot : '1;
            end else begin
                r_ssd    <= 8'hFF;
                r_anodes <= '1;
            end
        end
    end

    assign bus.pending = r_pending;
    assign frame_start = r_frame_start;
    assign anodes      = r_anodes;
    assign SSD         = r_ssd;

endmodule
